// File: rtl/riscv_mc_pkg.sv
// Shared encodings for the multi-cycle RISC-V control FSM:
// states, opcodes, ALU operand/op codes and fault causes.
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADDR = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC_R  = 4'd6,
    S_EXEC_I  = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_FAULT   = 4'd10
  } state_t;

  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_ILLEGAL = 2'b01;
  localparam logic [1:0] FC_TIMEOUT = 2'b10;

endpackage

// File: rtl/riscv_multicycle_control_timer.sv
// mc_wait_timer: counts memory wait cycles; expired fires on the
// wait cycle that reaches LIMIT. LIMIT=0 never expires.
module mc_wait_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT + 1) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clear)
      cnt <= '0;
    else if (inc && LIMIT != 0)
      cnt <= cnt + W'(1);
  end

  generate
    if (LIMIT == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      assign expired = inc && (cnt == W'(LIMIT - 1));
    end
  endgenerate

endmodule

// File: rtl/riscv_multicycle_control.sv
// Multi-cycle RISC-V main control FSM with memory-ready handshake.
// Define MC_CTRL_PERF_EN to add cycle/instret performance counters.
module riscv_multicycle_control
  import riscv_mc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       Branch,
  output logic       PCSrc,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       instr_done,
  output logic       fault,
  output logic [1:0] fault_cause,
  output logic [3:0] state_dbg
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret_count
`endif
);

  state_t     state_q, state_d;
  logic [1:0] cause_d;
  logic       waiting, expired, hs;

  assign waiting = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                   (state_q == S_MEMWR);

  mc_wait_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst_n   (reset),
    .clear   (state_d != state_q),
    .inc     (waiting && !mem_ready),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_FETCH;
      fault_cause <= FC_NONE;
    end else begin
      state_q <= state_d;
      if (state_d == S_FAULT && state_q != S_FAULT)
        fault_cause <= cause_d;
    end
  end

  always_comb begin
    PCWrite    = 1'b0;
    Branch     = 1'b0;
    PCSrc      = 1'b0;
    IorD       = 1'b0;
    IRWrite    = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_REG;
    ALUOp      = ALUOP_ADD;
    instr_done = 1'b0;
    state_d    = state_q;
    cause_d    = FC_NONE;
    // reset masks the fetch handshake so reset shows the idle fetch
    hs         = mem_ready && reset;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        if (hs) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end else if (expired) begin
          state_d = S_FAULT;
          cause_d = FC_TIMEOUT;
        end
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMM;
        case (opcode)
          OP_LD, OP_SD: state_d = S_MEMADDR;
          OP_R:         state_d = S_EXEC_R;
          OP_I:         state_d = S_EXEC_I;
          OP_BEQ:       state_d = S_BRANCH;
          default: begin
            state_d = S_FAULT;
            cause_d = FC_ILLEGAL;
          end
        endcase
      end
      S_MEMADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        state_d = (opcode == OP_SD) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else if (expired) begin
          state_d = S_FAULT;
          cause_d = FC_TIMEOUT;
        end
      end
      S_MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else if (expired) begin
          state_d = S_FAULT;
          cause_d = FC_TIMEOUT;
        end
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUOp      = ALUOP_SUB;
        Branch     = 1'b1;
        PCSrc      = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_FAULT: ;
      default: begin
        state_d = S_FAULT;
        cause_d = FC_ILLEGAL;
      end
    endcase
  end

  assign fault     = (state_q == S_FAULT);
  assign state_dbg = state_q;

`ifdef MC_CTRL_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_count   <= '0;
      instret_count <= '0;
    end else begin
      if (state_q != S_FAULT)
        cycle_count <= cycle_count + CNT_W'(1);
      if (instr_done)
        instret_count <= instret_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_riscv_multicycle_control.sv
// Scoreboard bench for riscv_multicycle_control: driver queues the
// expected control vector per cycle, monitor compares on negedge.
module tb_riscv_multicycle_control;

  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] SD  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] AI  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset, zero, mem_ready;
  logic [6:0] opcode;
  logic       PCWrite, Branch, PCSrc, IorD, IRWrite, MemRead, MemWrite;
  logic       MemtoReg, RegWrite, ALUSrcA, instr_done, fault;
  logic [1:0] ALUSrcB, ALUOp, fault_cause;
  logic [3:0] state_dbg;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] cycle_count, instret_count;
`endif

  riscv_multicycle_control #(.TIMEOUT_CYCLES(15), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .Branch(Branch),
    .PCSrc(PCSrc), .IorD(IorD), .IRWrite(IRWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .instr_done(instr_done), .fault(fault), .fault_cause(fault_cause),
    .state_dbg(state_dbg)
`ifdef MC_CTRL_PERF_EN
    , .cycle_count(cycle_count), .instret_count(instret_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [21:0] v;
    string       name;
    bit          pc;
    logic [31:0] ec;
    logic [31:0] ei;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  string       tag = "init";
  bit          perf_chk = 1'b0;
  logic [31:0] perf_c = '0;
  logic [31:0] perf_i = '0;

  // Hand-written control table, field order matches the monitor concat
  function automatic logic [21:0] expv(input int st, input bit hs,
                                       input logic [1:0] fc);
    logic pcw, br, pcs, iord, irw, mr, mw, m2r, rw, sa, dn, fl;
    logic [1:0] sb, op;
    {pcw, br, pcs, iord, irw, mr, mw, m2r, rw, sa, dn, fl} = '0;
    sb = 2'b00;
    op = 2'b00;
    case (st)
      0: begin mr = 1; sb = 2'b01; pcw = hs; irw = hs; end
      1: sb = 2'b10;
      2: begin sa = 1; sb = 2'b10; end
      3: begin mr = 1; iord = 1; end
      4: begin rw = 1; m2r = 1; dn = 1; end
      5: begin mw = 1; iord = 1; dn = hs; end
      6: begin sa = 1; op = 2'b10; end
      7: begin sa = 1; sb = 2'b10; end
      8: begin rw = 1; dn = 1; end
      9: begin sa = 1; op = 2'b01; br = 1; pcs = 1; dn = 1; end
      10: fl = 1;
      default: ;
    endcase
    return {pcw, br, pcs, iord, irw, mr, mw, m2r, rw, sa, sb, op,
            dn, fl, fc, 4'(st)};
  endfunction

  task automatic cyc(input int st, input bit rdy, input logic [6:0] op,
                     input bit z = 1'b0, input bit rs = 1'b1,
                     input logic [1:0] fc = 2'b00);
    exp_t e;
    reset     = rs;
    mem_ready = rdy;
    opcode    = op;
    zero      = z;
    e.v    = expv(st, rdy && rs, fc);
    e.name = tag;
    e.pc   = perf_chk;
    e.ec   = perf_c;
    e.ei   = perf_i;
    q.push_back(e);
    perf_chk = 1'b0;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t        e;
    logic [21:0] act;
    if (q.size() != 0) begin
      e   = q.pop_front();
      act = {PCWrite, Branch, PCSrc, IorD, IRWrite, MemRead, MemWrite,
             MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, instr_done,
             fault, fault_cause, state_dbg};
      n_cmp++;
      if (act !== e.v) begin
        n_bad++;
        $display("FAIL %s ctrl: got %h want %h (t=%0t)",
                 e.name, act, e.v, $time);
      end
`ifdef MC_CTRL_PERF_EN
      if (e.pc) begin
        n_cmp++;
        if (cycle_count !== e.ec || instret_count !== e.ei) begin
          n_bad++;
          $display("FAIL %s perf: got cyc=%0d ret=%0d want cyc=%0d ret=%0d",
                   e.name, cycle_count, instret_count, e.ec, e.ei);
        end
      end
`endif
    end
  end

  initial begin
    reset     = 1'b0;
    mem_ready = 1'b1;
    opcode    = RT;
    zero      = 1'b0;
    @(posedge clk);
    #1;

    tag = "reset_hold";
    cyc(0, 1, RT, 0, 0);
    cyc(0, 1, RT, 0, 0);

    tag = "addi_x3";
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, AI); cyc(1, 1, AI); cyc(7, 1, AI); cyc(8, 1, AI);
    end
    tag = "perf_after_3";
    perf_chk = 1; perf_c = 32'd12; perf_i = 32'd3;
    cyc(0, 1, RT);
    cyc(1, 1, RT);
    tag = "perf_reset_mid";
    perf_chk = 1; perf_c = 32'd0; perf_i = 32'd0;
    cyc(0, 1, RT, 0, 0);

    tag = "rtype";
    cyc(0, 1, RT); cyc(1, 1, RT); cyc(6, 1, RT); cyc(8, 1, RT);

    tag = "ld_wait";
    cyc(0, 1, LD); cyc(1, 1, LD); cyc(2, 1, LD);
    cyc(3, 0, LD); cyc(3, 0, LD); cyc(3, 0, LD); cyc(3, 1, LD);
    cyc(4, 1, LD);

    tag = "sd_wait";
    cyc(0, 1, SD); cyc(1, 1, SD); cyc(2, 1, SD);
    cyc(5, 0, SD); cyc(5, 1, SD);

    tag = "beq_z0";
    cyc(0, 1, BQ); cyc(1, 1, BQ); cyc(9, 1, BQ, 0);
    tag = "beq_z1";
    cyc(0, 1, BQ); cyc(1, 1, BQ); cyc(9, 1, BQ, 1);

    tag = "tmo_ready_at_15";
    for (int i = 0; i < 14; i++) cyc(0, 0, AI);
    cyc(0, 1, AI); cyc(1, 1, AI); cyc(7, 1, AI); cyc(8, 1, AI);

    tag = "tmo_stuck";
    for (int i = 0; i < 15; i++) cyc(0, 0, AI);
    tag = "tmo_fault";
    cyc(10, 1, AI, 0, 1, 2'b10);
    cyc(10, 0, AI, 0, 1, 2'b10);
    tag = "tmo_reset";
    cyc(0, 1, RT, 0, 0);

    tag = "illegal";
    cyc(0, 1, BAD); cyc(1, 1, BAD);
    tag = "illegal_fault";
    cyc(10, 1, BAD, 0, 1, 2'b01);
    cyc(10, 1, RT, 0, 1, 2'b01);
    cyc(10, 0, LD, 0, 1, 2'b01);
    tag = "illegal_reset";
    cyc(0, 0, RT, 0, 0);

    tag = "sd_reset_mid";
    cyc(0, 1, SD); cyc(1, 1, SD); cyc(2, 1, SD); cyc(5, 0, SD);
    cyc(0, 1, SD, 0, 0);
    tag = "after_reset_addi";
    cyc(0, 1, AI); cyc(1, 1, AI); cyc(7, 1, AI); cyc(8, 1, AI);

    @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d queued want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
